// File: rtl/botao_debounce.sv
// Pushbutton conditioner: two-flop synchronizer, debounce FSM with press/release
// pulses and a long-press "held" indication. All outputs are registered.
module botao_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned HOLD_CYCLES     = 50000000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_held
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_PRE = HW'(HOLD_CYCLES - 1);
  localparam logic RELEASED_PIN = ACTIVE_LOW ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  state_t        state_r;
  logic          sync1_r;
  logic          sync2_r;
  logic          sample_s;
  logic [CW-1:0] cnt_r;
  logic [HW-1:0] hold_cnt_r;
  logic [HW-1:0] hold_next_s;
  logic          held_next_s;

  // Two-flop synchronizer; resets to the idle pin level so no false press is seen.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= RELEASED_PIN;
      sync2_r <= RELEASED_PIN;
    end else begin
      sync1_r <= btn_raw;
      sync2_r <= sync1_r;
    end
  end

  // Normalize polarity after the synchronizer: 1 means pressed.
  always_comb begin
    sample_s = ACTIVE_LOW ? ~sync2_r : sync2_r;
  end

  // Saturating hold-counter advance and the held flag it produces.
  always_comb begin
    hold_next_s = hold_cnt_r;
    held_next_s = btn_held;
    if (hold_cnt_r != HOLD_MAX) begin
      hold_next_s = hold_cnt_r + HW'(1);
      if (hold_cnt_r == HOLD_PRE) begin
        held_next_s = 1'b1;
      end else begin
        held_next_s = btn_held;
      end
    end else begin
      hold_next_s = hold_cnt_r;
      held_next_s = btn_held;
    end
  end

  // Debounce FSM with registered level, pulses and held flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      hold_cnt_r  <= {HW{1'b0}};
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_held    <= 1'b0;
    end else begin
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      case (state_r)
        IDLE: begin
          if (sample_s) begin
            state_r <= PRESS_WAIT;
            cnt_r   <= CW'(1);
          end else begin
            cnt_r   <= {CW{1'b0}};
          end
        end
        PRESS_WAIT: begin
          if (!sample_s) begin
            state_r <= IDLE;
            cnt_r   <= {CW{1'b0}};
          end else if (cnt_r == CNT_LAST) begin
            state_r    <= PRESSED;
            cnt_r      <= {CW{1'b0}};
            btn_level  <= 1'b1;
            btn_press  <= 1'b1;
            hold_cnt_r <= {HW{1'b0}};
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        PRESSED: begin
          hold_cnt_r <= hold_next_s;
          btn_held   <= held_next_s;
          if (!sample_s) begin
            state_r <= RELEASE_WAIT;
            cnt_r   <= CW'(1);
          end else begin
            cnt_r   <= {CW{1'b0}};
          end
        end
        RELEASE_WAIT: begin
          if (sample_s) begin
            // Glitch during release: resume pressed without clearing hold progress.
            state_r    <= PRESSED;
            cnt_r      <= {CW{1'b0}};
            hold_cnt_r <= hold_next_s;
            btn_held   <= held_next_s;
          end else if (cnt_r == CNT_LAST) begin
            state_r     <= IDLE;
            cnt_r       <= {CW{1'b0}};
            btn_level   <= 1'b0;
            btn_release <= 1'b1;
            btn_held    <= 1'b0;
            hold_cnt_r  <= {HW{1'b0}};
          end else begin
            cnt_r      <= cnt_r + CW'(1);
            hold_cnt_r <= hold_next_s;
            btn_held   <= held_next_s;
          end
        end
        default: begin
          state_r    <= IDLE;
          cnt_r      <= {CW{1'b0}};
          hold_cnt_r <= {HW{1'b0}};
          btn_level  <= 1'b0;
          btn_held   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_botao_debounce.sv
// Scoreboard bench for botao_debounce (DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, active-low pin):
// stimulus queues expected press/release/held events, a monitor pops and compares them.
module tb_botao_debounce;

  logic clk;
  logic reset;
  logic btn_raw;
  logic btn_level;
  logic btn_press;
  logic btn_release;
  logic btn_held;

  int errors = 0;
  int checks = 0;
  int edge_cnt = 0;

  typedef struct {
    int   kind;      // 1 press, 2 release, 3 held rise
    int   at_edge;
    logic level;
  } exp_t;

  exp_t exp_q[$];
  logic held_q  = 1'b0;
  logic press_q = 1'b0;
  logic rel_q   = 1'b0;

  botao_debounce #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES(10),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release),
    .btn_held(btn_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic push_exp(input int kind, input int at_edge, input logic level);
    exp_t e;
    e.kind = kind;
    e.at_edge = at_edge;
    e.level = level;
    exp_q.push_back(e);
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b expected %b at edge %0d", name, act, req, edge_cnt);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    check_bit({name, "_level"}, btn_level, 1'b0);
    check_bit({name, "_press"}, btn_press, 1'b0);
    check_bit({name, "_release"}, btn_release, 1'b0);
    check_bit({name, "_held"}, btn_held, 1'b0);
  endtask

  // Monitor: every observed output event must match the head of the scoreboard.
  always @(negedge clk) begin
    logic [3:1] ev;
    exp_t e;
    ev = {btn_held & ~held_q, btn_release, btn_press};
    for (int k = 1; k <= 3; k++) begin
      if (ev[k]) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: kind %0d at edge %0d, none expected", k, edge_cnt);
        end else begin
          e = exp_q.pop_front();
          if (e.kind != k || e.at_edge != edge_cnt || e.level !== btn_level) begin
            errors++;
            $display("FAIL event: got kind %0d edge %0d level %b expected kind %0d edge %0d level %b",
                     k, edge_cnt, btn_level, e.kind, e.at_edge, e.level);
          end
        end
      end
    end
    held_q = btn_held;
  end

  // Pulse exclusivity, one-cycle pulses and debounce/hold counter bounds.
  always @(negedge clk) begin
    checks += 4;
    assert (!(btn_press && btn_release)) else begin
      errors++;
      $display("FAIL pulse_exclusive: press %b release %b expected not both at edge %0d", btn_press, btn_release, edge_cnt);
    end
    assert (!(btn_press && press_q) && !(btn_release && rel_q)) else begin
      errors++;
      $display("FAIL pulse_width: press %b/%b release %b/%b expected single-cycle at edge %0d",
               press_q, btn_press, rel_q, btn_release, edge_cnt);
    end
    assert (int'(dut.cnt_r) <= 3) else begin
      errors++;
      $display("FAIL cnt_bound: got %0d expected <= 3 at edge %0d", dut.cnt_r, edge_cnt);
    end
    assert (int'(dut.hold_cnt_r) <= 10) else begin
      errors++;
      $display("FAIL hold_bound: got %0d expected <= 10 at edge %0d", dut.hold_cnt_r, edge_cnt);
    end
    press_q = btn_press;
    rel_q = btn_release;
  end

  initial begin
    int t0;
    reset = 1'b1;
    btn_raw = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Stable press: press at +6, held 10 edges later.
    btn_raw = 1'b0;
    t0 = edge_cnt;
    push_exp(1, t0 + 6, 1'b1);
    push_exp(3, t0 + 16, 1'b1);
    repeat (7) @(negedge clk);
    check_bit("press_one_cycle", btn_press, 1'b0);
    check_bit("level_after_press", btn_level, 1'b1);
    repeat (13) @(negedge clk);
    check_bit("held_set", btn_held, 1'b1);

    // Two-cycle release glitch: no pulses, level and held unchanged.
    btn_raw = 1'b1;
    repeat (2) @(negedge clk);
    btn_raw = 1'b0;
    repeat (8) @(negedge clk);
    check_bit("glitch_level", btn_level, 1'b1);
    check_bit("glitch_held", btn_held, 1'b1);

    // Committed release 6 edges later.
    btn_raw = 1'b1;
    push_exp(2, edge_cnt + 6, 1'b0);
    repeat (6) @(negedge clk);
    check_bit("release_level", btn_level, 1'b0);
    check_bit("release_held_clear", btn_held, 1'b0);
    repeat (4) @(negedge clk);

    // Bouncing press (3 low, 1 high) x5: never commits.
    for (int i = 0; i < 5; i++) begin
      btn_raw = 1'b0;
      repeat (3) @(negedge clk);
      btn_raw = 1'b1;
      repeat (1) @(negedge clk);
      check_bit("bounce_level", btn_level, 1'b0);
    end
    repeat (8) @(negedge clk);
    check_bit("bounce_level_final", btn_level, 1'b0);

    // Reset while pressed: abort without release, re-press after reset.
    btn_raw = 1'b0;
    push_exp(1, edge_cnt + 6, 1'b1);
    repeat (8) @(negedge clk);
    check_bit("pre_reset_level", btn_level, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check_outputs_zero("mid_reset");
    reset = 1'b0;
    push_exp(1, edge_cnt + 6, 1'b1);
    repeat (8) @(negedge clk);
    btn_raw = 1'b1;
    push_exp(2, edge_cnt + 6, 1'b0);
    repeat (10) @(negedge clk);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drained: got %0d pending events expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/botao_debounce.md
BOTAO_DEBOUNCE -- requirements
Module: botao_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000: consecutive stable synchronized samples required to commit a level change; legal range 2..2^20.
REQ-002 Parameter HOLD_CYCLES, default 50000000: cycles in committed-pressed state before btn_held asserts; must be >= 1.
REQ-003 Parameter ACTIVE_LOW, default 1: 1 = btn_raw low means pressed (board pushbutton); 0 = btn_raw high means pressed.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 btn_raw  input  1  asynchronous, bouncing pushbutton pin.
REQ-007 btn_level  output  1  debounced level, 1 = pressed; drives the downstream PIO in_port.
REQ-008 btn_press  output  1  one-cycle pulse on committed press.
REQ-009 btn_release  output  1  one-cycle pulse on committed release.
REQ-010 btn_held  output  1  level: pressed continuously for HOLD_CYCLES after press commit.

Function
REQ-011 Synchronizer SHALL be two flops in series on btn_raw; polarity normalization per ACTIVE_LOW SHALL follow the second flop; result is sample s (1 = pressed).
REQ-012 FSM states SHALL be IDLE (released stable), PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-013 IDLE: s=1 -> PRESS_WAIT, cnt<=1; s=0 -> stay, cnt<=0.
REQ-014 PRESS_WAIT: s=0 -> IDLE, cnt<=0 (bounce discards progress); s=1 and cnt==DEBOUNCE_CYCLES-1 -> PRESSED, btn_level<=1, btn_press<=1, cnt<=0; else cnt<=cnt+1.
REQ-015 PRESSED: s=0 -> RELEASE_WAIT, cnt<=1; s=1 -> stay, hold counter advances per REQ-018.
REQ-016 RELEASE_WAIT: s=1 -> PRESSED, cnt<=0, btn_level stays 1, btn_held unchanged, hold counter resumes without clearing; s=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE, btn_level<=0, btn_release<=1, btn_held<=0, hold counter<=0; else cnt<=cnt+1.
REQ-017 Debounce counter width SHALL be ceil(log2(DEBOUNCE_CYCLES)); it SHALL never exceed DEBOUNCE_CYCLES-1 and never wrap.
REQ-018 Hold counter SHALL be a separate counter, ceil(log2(HOLD_CYCLES+1)) bits, incrementing each cycle in PRESSED/RELEASE_WAIT, saturating at HOLD_CYCLES; btn_held<=1 on the edge it reaches HOLD_CYCLES and stays 1 until release commit.
REQ-019 btn_press and btn_release SHALL be high for exactly one cycle, never simultaneously, and SHALL deassert on the following edge regardless of input.
REQ-020 Latency: btn_level SHALL change on rising edge DEBOUNCE_CYCLES+2 counted from the first edge sampling the new stable btn_raw; pulses coincide with that cycle.
REQ-021 All outputs SHALL be registered; no combinational path from btn_raw to any output.

Reset
REQ-022 On reset=1 at a rising edge: state<=IDLE, cnt<=0, hold counter<=0, btn_level/btn_press/btn_release/btn_held<=0, both synchronizer flops <= released pin value (1 if ACTIVE_LOW else 0).
REQ-023 Reset asserted mid-PRESS_WAIT, PRESSED or RELEASE_WAIT SHALL abort with no btn_release pulse; a button still pressed after reset deasserts SHALL be re-debounced from IDLE and produce a fresh btn_press.
REQ-024 Reset SHALL take priority over all other state updates in the same cycle.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, ACTIVE_LOW=1)
REQ-025 btn_raw driven 0 before edge 1 and held -> btn_level=1 and btn_press=1 after edge 6; btn_press=0 after edge 7.
REQ-026 btn_raw 0 for 3 cycles, 1 for 1 cycle, repeated 5 times -> btn_level, btn_press remain 0 throughout.
REQ-027 Stable press then btn_raw 1 held -> btn_release pulses once, exactly 6 edges after release; btn_level=0 at the same edge.
REQ-028 Stable press held -> btn_held=1 exactly 10 edges after btn_press edge; a 2-cycle release glitch leaves btn_level=1, btn_held=1, no pulses.
REQ-029 reset=1 for one cycle while PRESSED with btn_raw=0 -> all outputs 0 next cycle, no btn_release; btn_press reasserts 6 edges after reset deasserts.
REQ-030 Bench SHALL check pulse exclusivity (REQ-019) and counter bounds (REQ-017) by assertion in all scenarios.
